// File: rtl/common_lib_pseudo_reverse_buffer.sv
`default_nettype none
// ============================================================================
// Module   : common_lib_pseudo_reverse_buffer
// Brief    : Streaming ping-pong reorder buffer. Frames of N = B**S elements
//            arrive in natural order and leave in base-B pseudo-reverse order.
//            The step is chosen per frame. Two banks let one frame be written
//            while the previous frame is read out.
// Options  : PSEUDO_REVERSE_BUFFER_STEP_ERR_EN adds a sticky 'err' output.
//            It flags frames whose step was out of range.
// Revision : 1.0 - initial release
// ============================================================================
module common_lib_pseudo_reverse_buffer #(
  parameter int S    = 4,   // base-B digits per index (>= 2)
  parameter int B    = 2,   // radix, power of two (>= 2)
  parameter int OP_W = 32   // element width
) (
  input  logic                  clk,
  input  logic                  a_rst,
  input  logic [OP_W-1:0]       in_data,
  input  logic [$clog2(S)-1:0]  in_step,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [OP_W-1:0]       out_data,
  output logic                  out_last,
  output logic                  out_vld,
  input  logic                  out_rdy
`ifdef PSEUDO_REVERSE_BUFFER_STEP_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int B_W = $clog2(B);
  localparam int S_W = $clog2(S);
  localparam int N   = B ** S;
  localparam int N_W = S * B_W;

  localparam logic [N_W-1:0] c_PTR_LAST = '1;
  localparam logic [N_W-1:0] c_PTR_ONE  = {{(N_W-1){1'b0}}, 1'b1};
  localparam logic [S_W:0]   c_S_EXT    = (S_W+1)'(S);
  localparam logic [S_W-1:0] c_STEP_MAX = S_W'(S - 1);

  // Pseudo-reverse of index v: digits below 'step' stay in place, and the
  // remaining upper digits appear in reversed order. The map is its own
  // inverse, so it serves as the read address generator directly.
  function automatic logic [N_W-1:0] f_pr(input logic [N_W-1:0] v,
                                          input logic [S_W-1:0] step);
    logic [N_W-1:0] r;
    int             src;
    r = '0;
    for (int s = 0; s < S; s++) begin
      if (s < int'(step)) begin
        src = s;
      end else begin
        src = S - 1 - (s - int'(step));
      end
      r[s*B_W +: B_W] = v[src*B_W +: B_W];
    end
    return r;
  endfunction

  // Storage and control state
  logic [OP_W-1:0] r_mem [0:2*N-1];
  logic [1:0]      r_full;
  logic [S_W-1:0]  r_step [0:1];
  logic [N_W-1:0]  r_wr_ptr;
  logic            r_wr_bank;
  logic [N_W-1:0]  r_rd_ptr;
  logic            r_rd_bank;

  logic            w_wr_en;
  logic            w_wr_first;
  logic            w_wr_last;
  logic            w_step_oor;
  logic [S_W-1:0]  w_step_clamped;
  logic            w_load;
  logic            w_rd_last;
  logic [N_W-1:0]  w_rd_addr;

  // Input ready is held low while reset is asserted. Otherwise it tracks
  // whether the bank currently being filled is free.
  assign in_rdy     = ~a_rst & ~r_full[r_wr_bank];
  assign w_wr_en    = in_vld & in_rdy;
  assign w_wr_first = (r_wr_ptr == '0);
  assign w_wr_last  = (r_wr_ptr == c_PTR_LAST);

  // Steps that cannot address a digit collapse to S-1, which is the identity order.
  assign w_step_oor     = ({1'b0, in_step} >= c_S_EXT);
  assign w_step_clamped = w_step_oor ? c_STEP_MAX : in_step;

  // The output register advances whenever it is empty or being consumed.
  assign w_load    = r_full[r_rd_bank] & (~out_vld | out_rdy);
  assign w_rd_last = (r_rd_ptr == c_PTR_LAST);
  assign w_rd_addr = f_pr(r_rd_ptr, r_step[r_rd_bank]);

  // Store each accepted element at its natural position in the fill bank.
  // Contents need no reset because the full flags gate every read.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[{r_wr_bank, r_wr_ptr}] <= in_data;
    end
  end

  // Write pointer and bank selection, plus the per-frame step latch.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_wr_ptr  <= '0;
      r_wr_bank <= 1'b0;
      r_step[0] <= '0;
      r_step[1] <= '0;
    end else if (w_wr_en) begin
      if (w_wr_first) begin
        r_step[r_wr_bank] <= w_step_clamped;
      end
      r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_wr_last) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Bank occupancy. A bank is set when its last element is written and cleared
  // when its last element is read. Set and clear always target different banks.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_wr_en && w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_load && w_rd_last) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Output register and read pointer. The outputs hold while stalled, and
  // valid drops once the current element is taken with nothing behind it.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      out_data  <= '0;
      out_last  <= 1'b0;
      out_vld   <= 1'b0;
      r_rd_ptr  <= '0;
      r_rd_bank <= 1'b0;
    end else if (w_load) begin
      out_data <= r_mem[{r_rd_bank, w_rd_addr}];
      out_last <= w_rd_last;
      out_vld  <= 1'b1;
      r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      if (w_rd_last) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end
  end

`ifdef PSEUDO_REVERSE_BUFFER_STEP_ERR_EN
  // Sticky flag for a frame that started with an out-of-range step.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      err <= 1'b0;
    end else if (w_wr_en && w_wr_first && w_step_oor) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_common_lib_pseudo_reverse_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_common_lib_pseudo_reverse_buffer
// Brief    : Self-checking bench for the pseudo-reverse buffer (S=3, B=2).
//            Expected output elements are queued as frames are driven.
//            They are checked as the DUT hands them out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_common_lib_pseudo_reverse_buffer;

  localparam int S    = 3;
  localparam int B    = 2;
  localparam int OP_W = 32;
  localparam int N    = 8;

  logic            clk;
  logic            a_rst;
  logic [OP_W-1:0] in_data;
  logic [1:0]      in_step;
  logic            in_vld;
  logic            in_rdy;
  logic [OP_W-1:0] out_data;
  logic            out_last;
  logic            out_vld;
  logic            out_rdy;
`ifdef PSEUDO_REVERSE_BUFFER_STEP_ERR_EN
  logic            err;
`endif

  common_lib_pseudo_reverse_buffer #(.S(S), .B(B), .OP_W(OP_W)) dut (
    .clk      (clk),
    .a_rst    (a_rst),
    .in_data  (in_data),
    .in_step  (in_step),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .out_data (out_data),
    .out_last (out_last),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy)
`ifdef PSEUDO_REVERSE_BUFFER_STEP_ERR_EN
    ,
    .err      (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_pop = 0;
  logic [OP_W:0] sb [$];

  // Output position -> source index, for steps 0..3 of an S=3, B=2 frame.
  // Step 3 is out of range and is clamped to the identity order.
  int tab [4][8] = '{'{0, 4, 2, 6, 1, 5, 3, 7},
                     '{0, 1, 4, 5, 2, 3, 6, 7},
                     '{0, 1, 2, 3, 4, 5, 6, 7},
                     '{0, 1, 2, 3, 4, 5, 6, 7}};

  // Scoreboard: every output handshake is compared against the queue head
  always @(negedge clk) begin
    logic [OP_W:0] exp_e;
    if (!a_rst && out_vld && out_rdy) begin
      total++;
      n_pop++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got last=%0b data=%0d, expected no output", out_last, out_data);
      end else begin
        exp_e = sb.pop_front();
        if ({out_last, out_data} !== exp_e) begin
          bad++;
          $display("FAIL sb_data: got last=%0b data=%0d, expected last=%0b data=%0d",
                   out_last, out_data, exp_e[OP_W], exp_e[OP_W-1:0]);
        end
      end
    end
  end

  // Drive n elements (base+i) with the frame step on element 0 only.
  // Optionally queue the full frame's expected output order.
  task automatic send_frame(input int base, input int step, input int n,
                            input bit push, output int stalls);
    bit acc;
    int cnt;
    stalls = 0;
    if (push) begin
      for (int r = 0; r < N; r++) begin
        sb.push_back({(r == N-1), 32'(base + tab[step][r])});
      end
    end
    for (int i = 0; i < n; i++) begin
      in_vld  = 1'b1;
      in_data = 32'(base + i);
      in_step = (i == 0) ? 2'(step) : 2'($urandom_range(0, 3));
      acc = 1'b0;
      cnt = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_rdy;
        @(posedge clk);
        #1;
        if (!acc) begin
          stalls++;
          cnt++;
          if (cnt > 200) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_rdy=%0b, expected 1 within 200 cycles", in_rdy);
            in_vld = 1'b0;
            return;
          end
        end
      end
    end
    in_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d, expected 0", sb.size());
    end
  endtask

  task automatic test_reset();
    a_rst = 1'b1; in_vld = 1'b0; in_data = '0; in_step = '0; out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({out_vld, out_last} !== 2'b00) begin
      bad++; $display("FAIL rst_ctl: vld/last=%b, expected 00", {out_vld, out_last});
    end
    total++;
    if (out_data !== '0) begin
      bad++; $display("FAIL rst_data: got %0d, expected 0", out_data);
    end
    total++;
    if (in_rdy !== 1'b0) begin
      bad++; $display("FAIL rst_rdy: got %0b, expected 0", in_rdy);
    end
`ifdef PSEUDO_REVERSE_BUFFER_STEP_ERR_EN
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL rst_err: got %0b, expected 0", err);
    end
`endif
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1) begin
      bad++; $display("FAIL rst_release_rdy: got %0b, expected 1", in_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  // Single frame with a given step; also checks the two-cycle latency
  task automatic test_order(input int step, input int base);
    int st;
    send_frame(base, step, N, 1'b1, st);
    @(negedge clk);
    total++;
    if (out_vld !== 1'b0) begin
      bad++; $display("FAIL latency_early step=%0d: out_vld=%0b, expected 0", step, out_vld);
    end
    @(negedge clk);
    total++;
    if (out_vld !== 1'b1) begin
      bad++; $display("FAIL latency step=%0d: out_vld=%0b, expected 1", step, out_vld);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int st0, st1, run, k;
    st0 = 0; st1 = 0; run = 0; k = 0;
    fork
      begin
        send_frame(200, 0, N, 1'b1, st0);
        send_frame(300, 1, N, 1'b1, st1);
      end
      begin
        while (!out_vld && k < 100) begin
          @(negedge clk);
          k++;
        end
        for (int j = 0; j < 2*N; j++) begin
          if (out_vld) run++;
          @(negedge clk);
        end
      end
    join
    total++;
    if (st0 + st1 != 0) begin
      bad++; $display("FAIL b2b_stall: in_rdy low for %0d cycles, expected 0", st0 + st1);
    end
    total++;
    if (run != 2*N) begin
      bad++; $display("FAIL b2b_rate: valid run=%0d, expected %0d", run, 2*N);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int st, n0;
    out_rdy = 1'b0;
    n0 = n_pop;
    send_frame(0, 0, N, 1'b1, st);
    send_frame(100, 1, N, 1'b1, st);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({in_rdy, out_vld, out_last} !== 3'b010 || out_data !== '0) begin
        bad++;
        $display("FAIL bp_hold: rdy=%0b vld=%0b last=%0b data=%0d, expected 0 1 0 0",
                 in_rdy, out_vld, out_last, out_data);
      end
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    wait_drain();
    total++;
    if (n_pop - n0 != 2*N) begin
      bad++; $display("FAIL bp_count: outputs=%0d, expected %0d", n_pop - n0, 2*N);
    end
    @(negedge clk);
    total++;
    if (in_rdy !== 1'b1) begin
      bad++; $display("FAIL bp_release_rdy: got %0b, expected 1", in_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int st, n0, k;
    // Reset during a write, on element 5 of the frame
    send_frame(20, 0, 5, 1'b0, st);
    in_vld = 1'b1; in_data = 32'd25;
    #3;
    a_rst = 1'b1;
    #1;
    total++;
    if ({in_rdy, out_vld, out_last} !== 3'b000 || out_data !== '0) begin
      bad++; $display("FAIL rst_wr: rdy=%0b vld=%0b last=%0b data=%0d, expected all 0",
                      in_rdy, out_vld, out_last, out_data);
    end
    in_vld = 1'b0;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    // Reset during readout, while output 3 is being presented
    n0 = n_pop;
    k = 0;
    send_frame(50, 0, N, 1'b1, st);
    while (n_pop < n0 + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    #2;
    a_rst = 1'b1;
    #1;
    total++;
    if ({in_rdy, out_vld, out_last} !== 3'b000 || out_data !== '0) begin
      bad++; $display("FAIL rst_rd: rdy=%0b vld=%0b last=%0b data=%0d, expected all 0",
                      in_rdy, out_vld, out_last, out_data);
    end
    sb.delete();
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    test_order(1, 400);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_vld) k++;
    end
    total++;
    if (k != 0) begin
      bad++; $display("FAIL rst_stale: extra valid cycles=%0d, expected 0", k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_step_err();
`ifdef PSEUDO_REVERSE_BUFFER_STEP_ERR_EN
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL err_early: got %0b, expected 0", err);
    end
`endif
    test_order(3, 600);
`ifdef PSEUDO_REVERSE_BUFFER_STEP_ERR_EN
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_set: got %0b, expected 1", err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_order(0, 0);
    test_order(1, 10);
    test_order(2, 30);
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_step_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
